mem_bus_arbiter: RTL and testbench

//  Two-master arbiter and sequencer for the processor memory-mapped bus that feeds the address decoder (switches, 7-seg, data mem).

---
 rtl/mem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for the memory-mapped decoder bus: serialises one transaction at a time,
// times the decoder read latency and returns a one-cycle ack. Fixed m0 priority with an m1 starvation guard.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_ack_o,
  input  logic                  m1_req_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_ack_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_read_en_o,
  output logic                  bus_write_en_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  grant_owner_o,
  output logic                  busy_o
);

  localparam int LAT_W    = $clog2(READ_LATENCY + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(READ_LATENCY - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q;
  logic [LAT_W-1:0]      lat_q;
  logic [STARVE_W-1:0]   starve_q;
  logic                  owner_q;
  logic                  write_q;
  logic                  busy_q;
  logic                  read_en_q;
  logic                  write_en_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic                  req_any_d;
  logic                  grant_m1_d;
  logic                  write_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [STARVE_W-1:0]   starve_d;

  // Arbitration is only consumed in IDLE, so these feed registers and never reach the bus directly.
  always_comb begin
    req_any_d  = m0_req_i | m1_req_i;
    grant_m1_d = m1_req_i & (~m0_req_i | (starve_q == STARVE_MAX));
    write_d    = grant_m1_d ? m1_write_i : m0_write_i;
    addr_d     = grant_m1_d ? m1_addr_i  : m0_addr_i;
    wdata_d    = grant_m1_d ? m1_wdata_i : m0_wdata_i;
    starve_d   = '0;
    if (m1_req_i && !grant_m1_d) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      owner_q    <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (req_any_d) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            owner_q    <= grant_m1_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_en_q <= write_d;
            read_en_q  <= ~write_d;
          end
        end
        ISSUE: begin
          if (write_q) begin
            state_q <= RESP;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
          end else begin
            state_q <= WAIT;
            lat_q   <= LAT_LOAD;
          end
        end
        WAIT: begin
          // Capture lands in the same register update that raises ack, so RData is valid with it.
          if (lat_q == '0) begin
            if (owner_q) rdata1_q <= bus_rdata_i;
            else         rdata0_q <= bus_rdata_i;
            state_q <= RESP;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          owner_q <= 1'b0;
          write_q <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_rdata_o     = rdata0_q;
  assign m1_rdata_o     = rdata1_q;
  assign m0_ack_o       = ack0_q;
  assign m1_ack_o       = ack1_q;
  assign bus_addr_o     = addr_q;
  assign bus_wdata_o    = wdata_q;
  assign bus_read_en_o  = read_en_q;
  assign bus_write_en_o = write_en_q;
  assign grant_owner_o  = owner_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 has READ_LATENCY=1, instance 1 has READ_LATENCY=3.
// A transaction-level model predicts every output each cycle; directed steps pin literal values.
module tb_mem_bus_arbiter;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req[2], m0_write[2], m1_req[2], m1_write[2];
  logic [31:0] m0_addr[2], m0_wdata[2], m1_addr[2], m1_wdata[2], bus_rdata[2];
  logic [31:0] m0_rdata[2], m1_rdata[2], bus_addr[2], bus_wdata[2];
  logic        m0_ack[2], m1_ack[2], bus_re[2], bus_we[2], grant_owner[2], busy[2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      mem_bus_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .READ_LATENCY((gi == 0) ? 1 : 3),
        .STARVE_LIMIT(STARVE)
      ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req_i      (m0_req[gi]),
        .m0_write_i    (m0_write[gi]),
        .m0_addr_i     (m0_addr[gi]),
        .m0_wdata_i    (m0_wdata[gi]),
        .m0_rdata_o    (m0_rdata[gi]),
        .m0_ack_o      (m0_ack[gi]),
        .m1_req_i      (m1_req[gi]),
        .m1_write_i    (m1_write[gi]),
        .m1_addr_i     (m1_addr[gi]),
        .m1_wdata_i    (m1_wdata[gi]),
        .m1_rdata_o    (m1_rdata[gi]),
        .m1_ack_o      (m1_ack[gi]),
        .bus_addr_o    (bus_addr[gi]),
        .bus_read_en_o (bus_re[gi]),
        .bus_write_en_o(bus_we[gi]),
        .bus_wdata_o   (bus_wdata[gi]),
        .bus_rdata_i   (bus_rdata[gi]),
        .grant_owner_o (grant_owner[gi]),
        .busy_o        (busy[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Model: a transaction occupies cycles 1..len after its grant cycle (k = cycle index, 0 = idle).
  int          mk[2], mst[2];
  bit          mwr[2], mown[2];
  logic [31:0] maddr[2], mwd[2], mrd0[2], mrd1[2];

  function automatic int rl_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int txn_len(input int i);
    return mwr[i] ? 2 : 2 + rl_of(i);
  endfunction

  function automatic bit pick_m1(input int i);
    return m1_req[i] && (!m0_req[i] || mst[i] == STARVE);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mk[i] <= 0; mst[i] <= 0; mwr[i] <= 1'b0; mown[i] <= 1'b0;
        maddr[i] <= '0; mwd[i] <= '0; mrd0[i] <= '0; mrd1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mk[i] == 0) begin
          if (m0_req[i] || m1_req[i]) begin
            mown[i]  <= pick_m1(i);
            mwr[i]   <= pick_m1(i) ? m1_write[i] : m0_write[i];
            maddr[i] <= pick_m1(i) ? m1_addr[i]  : m0_addr[i];
            mwd[i]   <= pick_m1(i) ? m1_wdata[i] : m0_wdata[i];
            if (pick_m1(i))     mst[i] <= 0;
            else if (m1_req[i]) mst[i] <= (mst[i] < STARVE) ? mst[i] + 1 : STARVE;
            else                mst[i] <= 0;
            mk[i] <= 1;
          end else begin
            mst[i] <= 0;
          end
        end else begin
          if (!mwr[i] && mk[i] == 1 + rl_of(i)) begin
            if (mown[i]) mrd1[i] <= bus_rdata[i];
            else         mrd0[i] <= bus_rdata[i];
          end
          mk[i] <= (mk[i] == txn_len(i)) ? 0 : mk[i] + 1;
        end
      end
    end
  end

  bit glog0[$];
  int cmp_k, cmp_len;
  bit cmp_act;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cmp_k   = mk[i];
      cmp_len = txn_len(i);
      cmp_act = (cmp_k != 0);
      check1($sformatf("i%0d busy", i), busy[i], cmp_act);
      check1($sformatf("i%0d owner", i), grant_owner[i], cmp_act & mown[i]);
      check($sformatf("i%0d bus_addr", i), bus_addr[i], cmp_act ? maddr[i] : 32'h0);
      check($sformatf("i%0d bus_wdata", i), bus_wdata[i], cmp_act ? mwd[i] : 32'h0);
      check1($sformatf("i%0d bus_we", i), bus_we[i], cmp_k == 1 && mwr[i]);
      check1($sformatf("i%0d bus_re", i), bus_re[i], cmp_k == 1 && !mwr[i]);
      check1($sformatf("i%0d m0_ack", i), m0_ack[i], cmp_act && cmp_k == cmp_len && !mown[i]);
      check1($sformatf("i%0d m1_ack", i), m1_ack[i], cmp_act && cmp_k == cmp_len && mown[i]);
      check($sformatf("i%0d m0_rdata", i), m0_rdata[i], mrd0[i]);
      check($sformatf("i%0d m1_rdata", i), m1_rdata[i], mrd1[i]);
    end
    if (bus_we[0] || bus_re[0]) glog0.push_back(grant_owner[0]);
  end

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m0_req[i] = 1'b0; m0_write[i] = 1'b0; m0_addr[i] = '0; m0_wdata[i] = '0;
      m1_req[i] = 1'b0; m1_write[i] = 1'b0; m1_addr[i] = '0; m1_wdata[i] = '0;
      bus_rdata[i] = '0;
    end
  endtask

  bit exp_order[10];

  initial begin
    clear_inputs();
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        m0_req[i] = 1'($urandom); m0_write[i] = 1'($urandom);
        m0_addr[i] = $urandom; m0_wdata[i] = $urandom;
        m1_req[i] = 1'($urandom); m1_write[i] = 1'($urandom);
        m1_addr[i] = $urandom; m1_wdata[i] = $urandom; bus_rdata[i] = $urandom;
      end
      #1;
      check1("rst busy", busy[c % 2], 1'b0);
      check("rst bus_addr", bus_addr[c % 2], 32'h0);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check1("post-rst busy", busy[0], 1'b0);
    check1("post-rst m0_ack", m0_ack[0], 1'b0);

    // m0 write 0x100 <- 0xDEADBEEF on instance 0
    m0_req[0] = 1'b1; m0_write[0] = 1'b1; m0_addr[0] = 32'h100; m0_wdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    check1("wr c1 we", bus_we[0], 1'b1);
    check("wr c1 addr", bus_addr[0], 32'h100);
    check("wr c1 wdata", bus_wdata[0], 32'hDEADBEEF);
    check1("wr c1 ack", m0_ack[0], 1'b0);
    m0_addr[0] = 32'h999; m0_wdata[0] = 32'h0;
    @(negedge clk);
    check1("wr c2 ack", m0_ack[0], 1'b1);
    check1("wr c2 we", bus_we[0], 1'b0);
    check("wr c2 addr held", bus_addr[0], 32'h100);
    m0_req[0] = 1'b0;
    @(negedge clk);
    check1("wr c3 ack", m0_ack[0], 1'b0);

    // m1 read 0x200, latency 1
    @(negedge clk);
    m1_req[0] = 1'b1; m1_write[0] = 1'b0; m1_addr[0] = 32'h200; bus_rdata[0] = 32'hBAD0BAD0;
    @(negedge clk);
    check1("rd1 c1 re", bus_re[0], 1'b1);
    check1("rd1 c1 owner", grant_owner[0], 1'b1);
    check("rd1 c1 addr", bus_addr[0], 32'h200);
    @(negedge clk);
    check1("rd1 c2 owner", grant_owner[0], 1'b1);
    bus_rdata[0] = 32'h0000A5A5;
    @(negedge clk);
    check1("rd1 c3 ack", m1_ack[0], 1'b1);
    check("rd1 c3 rdata", m1_rdata[0], 32'h0000A5A5);
    check1("rd1 c3 owner", grant_owner[0], 1'b1);
    check("rd1 c3 m0_rdata", m0_rdata[0], 32'h0);
    bus_rdata[0] = 32'hFFFFFFFF; m1_req[0] = 1'b0;
    @(negedge clk);
    check1("rd1 c4 ack", m1_ack[0], 1'b0);
    check("rd1 c4 rdata held", m1_rdata[0], 32'h0000A5A5);
    check1("rd1 c4 owner", grant_owner[0], 1'b0);

    // Both masters requesting continuously: starvation guard
    @(negedge clk);
    glog0.delete();
    m0_req[0] = 1'b1; m0_write[0] = 1'b1; m0_addr[0] = 32'h10; m0_wdata[0] = 32'hAAAA0000;
    m1_req[0] = 1'b1; m1_write[0] = 1'b1; m1_addr[0] = 32'h20; m1_wdata[0] = 32'hBBBB0000;
    for (int c = 0; c < 80 && glog0.size() < 10; c++) @(negedge clk);
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("arb grant count", 32'(glog0.size()), 32'd10);
    for (int j = 0; j < 10; j++) begin
      if (j < glog0.size()) check1($sformatf("arb grant %0d", j), glog0[j], exp_order[j]);
      else check1($sformatf("arb grant %0d missing", j), 1'bx, exp_order[j]);
    end

    // m0 read, latency 3, on instance 1
    m0_req[1] = 1'b1; m0_write[1] = 1'b0; m0_addr[1] = 32'h300; bus_rdata[1] = 32'h0000DEAD;
    @(negedge clk);
    check1("rd3 c1 re", bus_re[1], 1'b1);
    check("rd3 c1 addr", bus_addr[1], 32'h300);
    @(negedge clk);
    bus_rdata[1] = 32'h00001111;
    @(negedge clk);
    bus_rdata[1] = 32'h00001111;
    @(negedge clk);
    check1("rd3 c4 ack", m0_ack[1], 1'b0);
    bus_rdata[1] = 32'h00002222;
    @(negedge clk);
    check1("rd3 c5 ack", m0_ack[1], 1'b1);
    check("rd3 c5 rdata", m0_rdata[1], 32'h00002222);
    bus_rdata[1] = 32'h00003333; m0_req[1] = 1'b0;
    @(negedge clk);
    check1("rd3 c6 ack", m0_ack[1], 1'b0);
    check("rd3 c6 rdata held", m0_rdata[1], 32'h00002222);

    // Reset during WAIT of an m1 read aborts it
    @(negedge clk);
    m1_req[1] = 1'b1; m1_write[1] = 1'b0; m1_addr[1] = 32'h400;
    @(negedge clk);
    @(negedge clk);
    check1("abort pre busy", busy[1], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("abort busy", busy[1], 1'b0);
    check1("abort re", bus_re[1], 1'b0);
    check1("abort we", bus_we[1], 1'b0);
    check("abort addr", bus_addr[1], 32'h0);
    check("abort m0_rdata cleared", m0_rdata[1], 32'h0);
    m1_req[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check1("abort no m1_ack", m1_ack[1], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    m0_req[1] = 1'b1; m0_write[1] = 1'b1; m0_addr[1] = 32'h500; m0_wdata[1] = 32'h12345678;
    @(negedge clk);
    check1("post-abort c1 we", bus_we[1], 1'b1);
    check("post-abort c1 wdata", bus_wdata[1], 32'h12345678);
    @(negedge clk);
    check1("post-abort c2 ack", m0_ack[1], 1'b1);
    check1("post-abort c2 m1_ack", m1_ack[1], 1'b0);
    m0_req[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
